// File: rtl/tlb_param.sv
// MIPS-style joint TLB with one-cycle instruction/data lookup ports, a
// TLBP/TLBR/TLBWI/TLBWR command sequencer and a wired-aware Random register.
// state | meaning
// IDLE  | cmd_ready high, waiting for cmd_valid
// EXEC  | probe/read captured, write commits at the closing edge
// RESP  | resp_valid high for one cycle
module tlb_param #(
  parameter  int ENTRIES = 16,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  input  logic [31:0] i_vaddr,
  input  logic        i_stall,
  input  logic        d_valid,
  input  logic        d_write,
  input  logic [31:0] d_vaddr,
  input  logic        d_stall,
  input  logic        d_flush,
  input  logic [31:0] EntryHi_in,
  input  logic [31:0] EntryLo0_in,
  input  logic [31:0] EntryLo1_in,
  input  logic [31:0] Index_in,
  input  logic [31:0] Wired_in,
  input  logic        wired_we,
  output logic [19:0] i_pfn,
  output logic        i_uncached,
  output logic        i_refill,
  output logic        i_invalid,
  output logic [19:0] d_pfn,
  output logic        d_uncached,
  output logic        d_refill,
  output logic        d_invalid,
  output logic        d_modify,
  output logic        multi_hit,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_op,
  output logic        cmd_ready,
  output logic        resp_valid,
  output logic [31:0] EntryHi_out,
  output logic [31:0] EntryLo0_out,
  output logic [31:0] EntryLo1_out,
  output logic [31:0] Index_out,
  output logic [31:0] Random_out
);

  localparam logic [1:0] OP_TLBP  = 2'd0;
  localparam logic [1:0] OP_TLBR  = 2'd1;
  localparam logic [1:0] OP_TLBWI = 2'd2;
  localparam logic [1:0] OP_TLBWR = 2'd3;
  localparam logic [IDX_W-1:0] RND_TOP = IDX_W'(ENTRIES - 1);

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } entry_t;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  entry_t             tlb [ENTRIES];
  state_t             state, state_n;
  logic [1:0]         op_q;
  logic               exec;
  logic [IDX_W-1:0]   rnd;
  logic [ENTRIES-1:0] i_match, d_match, p_match;
  logic [24:0]        i_half, d_half;
  logic               i_map, d_map;
  logic               i_vld_q, i_map_q, i_hit_q, i_v_q;
  logic               d_vld_q, d_map_q, d_hit_q, d_v_q, d_d_q, d_wr_q;
  logic [IDX_W-1:0]   wr_idx;
  entry_t             wr_entry, rd_entry;
  logic               unused_bits;

  function automatic logic hit_fn(input entry_t e, input logic [18:0] vpn2, input logic [7:0] asid);
    return (e.vpn2 == vpn2) && (e.g || (e.asid == asid));
  endfunction

  function automatic logic [IDX_W-1:0] first_idx(input logic [ENTRIES-1:0] m);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int k = ENTRIES - 1; k >= 0; k--)
      if (m[k]) r = IDX_W'(k);
    return r;
  endfunction

  function automatic logic many(input logic [ENTRIES-1:0] m);
    return |(m & (m - ENTRIES'(1)));
  endfunction

  // {pfn, c, d, v} of the half chosen by vaddr[12]
  function automatic logic [24:0] half_sel(input entry_t e, input logic odd);
    return odd ? {e.pfn1, e.c1, e.d1, e.v1} : {e.pfn0, e.c0, e.d0, e.v0};
  endfunction

  always_comb begin
    i_match = '0;
    d_match = '0;
    p_match = '0;
    for (int k = 0; k < ENTRIES; k++) begin
      i_match[k] = hit_fn(tlb[k], i_vaddr[31:13], EntryHi_in[7:0]);
      d_match[k] = hit_fn(tlb[k], d_vaddr[31:13], EntryHi_in[7:0]);
      p_match[k] = hit_fn(tlb[k], EntryHi_in[31:13], EntryHi_in[7:0]);
    end
  end

  assign i_half = half_sel(tlb[first_idx(i_match)], i_vaddr[12]);
  assign d_half = half_sel(tlb[first_idx(d_match)], d_vaddr[12]);
  assign i_map  = i_vaddr[31:30] != 2'b10;
  assign d_map  = d_vaddr[31:30] != 2'b10;

  // Translated fields are captured at lookup time so a same-cycle write cannot leak in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_vld_q <= 1'b0; i_map_q <= 1'b0; i_hit_q <= 1'b0; i_v_q <= 1'b0;
      i_pfn <= '0; i_uncached <= 1'b0;
    end else if (!i_stall) begin
      i_vld_q    <= i_valid;
      i_map_q    <= i_map;
      i_hit_q    <= |i_match;
      i_v_q      <= i_half[0];
      i_pfn      <= i_map ? i_half[24:5] : {3'b0, i_vaddr[28:12]};
      i_uncached <= i_map ? (i_half[4:2] == 3'b010) : i_vaddr[29];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_vld_q <= 1'b0; d_map_q <= 1'b0; d_hit_q <= 1'b0; d_v_q <= 1'b0; d_d_q <= 1'b0;
      d_wr_q <= 1'b0; d_pfn <= '0; d_uncached <= 1'b0;
    end else if (d_flush) begin
      d_vld_q <= 1'b0; d_map_q <= 1'b0; d_hit_q <= 1'b0; d_v_q <= 1'b0; d_d_q <= 1'b0;
      d_wr_q <= 1'b0; d_pfn <= '0; d_uncached <= 1'b0;
    end else if (!d_stall) begin
      d_vld_q    <= d_valid;
      d_map_q    <= d_map;
      d_hit_q    <= |d_match;
      d_v_q      <= d_half[0];
      d_d_q      <= d_half[1];
      d_wr_q     <= d_write;
      d_pfn      <= d_map ? d_half[24:5] : {3'b0, d_vaddr[28:12]};
      d_uncached <= d_map ? (d_half[4:2] == 3'b010) : d_vaddr[29];
    end
  end

  assign i_refill  = i_vld_q & i_map_q & ~i_hit_q;
  assign i_invalid = i_vld_q & i_map_q & i_hit_q & ~i_v_q;
  assign d_refill  = d_vld_q & d_map_q & ~d_hit_q;
  assign d_invalid = d_vld_q & d_map_q & d_hit_q & ~d_v_q;
  assign d_modify  = d_vld_q & d_map_q & d_wr_q & d_hit_q & d_v_q & ~d_d_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) multi_hit <= 1'b0;
    else      multi_hit <= (i_valid & ~i_stall & i_map & many(i_match)) |
                           (d_valid & ~d_stall & ~d_flush & d_map & many(d_match));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      op_q  <= 2'd0;
    end else begin
      state <= state_n;
      if (cmd_valid && cmd_ready) op_q <= cmd_op;
    end
  end

  always_comb begin
    state_n    = state;
    cmd_ready  = 1'b0;
    resp_valid = 1'b0;
    exec       = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_n = EXEC;
      end
      EXEC: begin
        exec    = 1'b1;
        state_n = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign wr_idx            = (op_q == OP_TLBWR) ? rnd : Index_in[IDX_W-1:0];
  assign wr_entry.vpn2     = EntryHi_in[31:13];
  assign wr_entry.asid     = EntryHi_in[7:0];
  assign wr_entry.g        = EntryLo0_in[0] & EntryLo1_in[0];
  assign wr_entry.pfn0     = EntryLo0_in[25:6];
  assign wr_entry.c0       = EntryLo0_in[5:3];
  assign wr_entry.d0       = EntryLo0_in[2];
  assign wr_entry.v0       = EntryLo0_in[1];
  assign wr_entry.pfn1     = EntryLo1_in[25:6];
  assign wr_entry.c1       = EntryLo1_in[5:3];
  assign wr_entry.d1       = EntryLo1_in[2];
  assign wr_entry.v1       = EntryLo1_in[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < ENTRIES; k++) tlb[k] <= '0;
    end else if (exec && (op_q == OP_TLBWI || op_q == OP_TLBWR)) begin
      tlb[wr_idx] <= wr_entry;
    end
  end

  assign rd_entry = tlb[Index_in[IDX_W-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Index_out    <= '0;
      EntryHi_out  <= '0;
      EntryLo0_out <= '0;
      EntryLo1_out <= '0;
    end else if (exec && op_q == OP_TLBP) begin
      Index_out <= (|p_match) ? 32'(first_idx(p_match)) : 32'h8000_0000;
    end else if (exec && op_q == OP_TLBR) begin
      EntryHi_out  <= {rd_entry.vpn2, 5'b0, rd_entry.asid};
      EntryLo0_out <= {6'b0, rd_entry.pfn0, rd_entry.c0, rd_entry.d0, rd_entry.v0, rd_entry.g};
      EntryLo1_out <= {6'b0, rd_entry.pfn1, rd_entry.c1, rd_entry.d1, rd_entry.v1, rd_entry.g};
    end
  end

  // Random never enters the wired region; an out-of-range Wired pins it to the top.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      rnd <= RND_TOP;
    else if (wired_we || Wired_in >= 32'(ENTRIES) || rnd == Wired_in[IDX_W-1:0] || rnd == '0)
      rnd <= RND_TOP;
    else
      rnd <= rnd - IDX_W'(1);
  end

  assign Random_out = 32'(rnd);

  assign unused_bits = ^{EntryHi_in[12:8], EntryLo0_in[31:26], EntryLo1_in[31:26],
                         Index_in[31:IDX_W], i_vaddr[11:0], d_vaddr[11:0]};

endmodule

// File: doc/tlb_param.md
TLB_PARAM -- requirements
Module: tlb_param

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, number of TLB entries; legal values are powers of two from 8 to 32.
REQ-002 SHALL have derived parameter IDX_W = clog2(ENTRIES), used as the index width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have instruction lookup inputs: i_valid (1), i_vaddr (32), i_stall (1).
REQ-006 SHALL have data lookup inputs: d_valid (1), d_write (1), d_vaddr (32), d_stall (1), d_flush (1).
REQ-007 SHALL have CP0 inputs, 32 bits each: EntryHi_in, EntryLo0_in, EntryLo1_in, Index_in, Wired_in; plus wired_we (1).
REQ-008 SHALL have instruction result outputs: i_pfn (20), i_uncached, i_refill, i_invalid (1 each).
REQ-009 SHALL have data result outputs: d_pfn (20), d_uncached, d_refill, d_invalid, d_modify (1 each).
REQ-010 SHALL have multi_hit, output, 1 bit: more than one entry matched.
REQ-011 SHALL have command inputs: cmd_valid (1) and cmd_op (2); op encoding 0=TLBP, 1=TLBR, 2=TLBWI, 3=TLBWR.
REQ-012 SHALL have command outputs: cmd_ready (1) and resp_valid (1).
REQ-013 SHALL have readback outputs, 32 bits each: EntryHi_out, EntryLo0_out, EntryLo1_out, Index_out, Random_out.

Function
REQ-014 Entry SHALL store VPN2[31:13], ASID[7:0], G, and per half PFN[19:0], C[2:0], D, V; only 4KB pages are supported.
REQ-015 Match SHALL require VPN2 equal and (G=1 or ASID equal to EntryHi_in[7:0]); the lowest matching index wins.
REQ-016 Even/odd half selection SHALL use vaddr[12].
REQ-017 Unmapped addresses (vaddr[31:30]=2'b10) SHALL give pfn={3'b0,vaddr[28:12]} and no exceptions.
REQ-018 For unmapped addresses, uncached SHALL equal vaddr[29]; for mapped addresses, uncached SHALL equal (C==3'b010).
REQ-019 Lookup latency SHALL be one cycle: compare and encode combinationally, then register index, hit, odd, kseg and vpn.
REQ-020 Instruction result registers SHALL load when i_stall=0; data result registers SHALL load when d_stall=0.
REQ-021 d_flush SHALL clear data result registers synchronously and take priority over d_stall.
REQ-022 Exceptions SHALL be gated by registered valid and mapped: refill=~hit; invalid=hit&~V; d_modify=d_write&hit&V&~D.
REQ-023 multi_hit SHALL pulse one cycle after any instruction or data lookup that matched two or more entries.
REQ-024 Command FSM SHALL have states IDLE, EXEC, RESP.
REQ-025 cmd_ready SHALL be 1 only in IDLE.
REQ-026 cmd_valid&cmd_ready SHALL latch cmd_op and move IDLE->EXEC.
REQ-027 The FSM SHALL move EXEC->RESP unconditionally, then RESP->IDLE; resp_valid SHALL be 1 only in RESP.
REQ-028 In EXEC, TLBP SHALL set Index_out = match ? {0,idx} : 32'h8000_0000.
REQ-029 In EXEC, TLBR SHALL read entry Index_in[IDX_W-1:0] into EntryHi_out and EntryLo0/1_out, with G replicated into bit 0 of both EntryLo outputs.
REQ-030 In EXEC, TLBWI SHALL write entry Index_in; TLBWR SHALL write entry Random_out; G = EntryLo0_in[0] & EntryLo1_in[0].
REQ-031 Writes SHALL commit at the clock edge ending EXEC; a lookup in the same cycle SHALL see the old contents.
REQ-032 Readback outputs SHALL hold their value until the next TLBP or TLBR.
REQ-033 Random SHALL decrement every cycle; at Wired_in value or 0 it SHALL wrap to ENTRIES-1.
REQ-034 wired_we=1 SHALL force Random to ENTRIES-1, overriding the decrement that cycle.
REQ-035 Random SHALL also load ENTRIES-1 when Wired_in >= ENTRIES.
REQ-036 Commands arriving while not in IDLE SHALL be ignored (not queued); the source holds cmd_valid.

Reset
REQ-037 rst=0 SHALL asynchronously clear all entries (V=0, G=0) and return the FSM to IDLE with cmd_ready=1.
REQ-038 On reset, all result, exception, multi_hit, resp_valid and readback outputs SHALL be 0; Random_out SHALL be ENTRIES-1.
REQ-039 Reset asserted mid-command SHALL abort it; no partial entry write SHALL occur.

Verification
REQ-040 Unmapped: d_vaddr=0xA000_1234, d_valid=1 -> next cycle d_pfn=0x00001, d_uncached=1, no exceptions.
REQ-041 Write then lookup: TLBWI Index=3, EntryHi=0x0040_0005, EntryLo0 PFN=0x12345 with V=1, D=0, C=3, EntryLo1 V=0. Then d_write to 0x0040_0010 -> d_pfn=0x12345, d_modify=1. Then read to 0x0040_1000 -> d_invalid=1.
REQ-042 Refill and probe: lookup of vaddr 0x7000_0000 with no matching entry -> refill=1. TLBP of the same VPN -> resp_valid exactly 2 cycles after acceptance, Index_out=0x8000_0000.
REQ-043 Random: Wired_in=4, ENTRIES=16 -> Random sequence 15,14,...,4,15. wired_we mid-sequence -> Random=15 on the next cycle.
REQ-044 Conflicts: a write to entry 5 in the same cycle as a lookup hitting entry 5 -> the lookup returns old data. Two entries with the same VPN2 and G=1 -> lowest index wins and multi_hit=1.
REQ-045 Flush and reset: d_flush together with d_stall -> data exceptions are 0. rst pulsed during EXEC of TLBWI -> the target entry stays V=0.
